bp_cacc_vdp_host_ctl: RTL and testbench

//  Host-side initiator for the vector-dot-product accelerator's uncached CSR port.

---
 rtl/bp_cacc_vdp_host_ctl.sv | 193 +++++++++++++++++++
 tb/tb_bp_cacc_vdp_host_ctl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cacc_vdp_host_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bp_cacc_vdp_host_ctl                                          |
// | Brief    : Programs one dot-product job over uncached CSR writes, polls  |
// |            START until it self-clears. Option: BP_CACC_VDP_HOST_CTL_TIMEOUT_EN |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bp_cacc_vdp_host_ctl #(
  parameter int unsigned paddr_width_p   = 40,
  parameter int unsigned dword_width_p   = 64,
  parameter logic [63:0] cacc_base_p     = 64'h0,
  parameter int unsigned poll_gap_p      = 4,
  parameter int unsigned timeout_polls_p = 1024
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     job_v_i,
  output logic                     job_ready_o,
  input  logic [dword_width_p-1:0] job_a_ptr_i,
  input  logic [dword_width_p-1:0] job_b_ptr_i,
  input  logic [dword_width_p-1:0] job_len_i,
  input  logic [dword_width_p-1:0] job_res_ptr_i,
  output logic                     io_cmd_v_o,
  input  logic                     io_cmd_ready_i,
  output logic                     io_cmd_wr_o,
  output logic [paddr_width_p-1:0] io_cmd_addr_o,
  output logic [2:0]               io_cmd_size_o,
  output logic [dword_width_p-1:0] io_cmd_data_o,
  input  logic                     io_resp_v_i,
  input  logic [dword_width_p-1:0] io_resp_data_i,
  output logic                     io_resp_yumi_o,
  output logic                     busy_o,
  output logic                     done_v_o,
  output logic                     done_err_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_RESP = 3'd2,
    S_GAP       = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  localparam logic [paddr_width_p-1:0] c_base  = paddr_width_p'(cacc_base_p);
  localparam int unsigned              c_gap_w = $clog2(poll_gap_p + 1) + 1;
  localparam logic [2:0]               c_step_poll = 3'd6;

  state_e                   r_state, w_state_nxt;
  logic [2:0]               r_step, w_step_nxt;
  logic [c_gap_w-1:0]       r_gap, w_gap_nxt;
  logic                     r_err, w_err_nxt;
  logic [dword_width_p-1:0] r_a, r_b, r_len, r_res;
  logic                     w_job_fire, w_len_bad;
  logic [8:0]               w_off;
  logic                     w_wr;
  logic [dword_width_p-1:0] w_data;

  assign w_job_fire = (r_state == S_IDLE) && job_v_i;
  assign w_len_bad  = (job_len_i == '0) || (job_len_i > dword_width_p'(8));

`ifdef BP_CACC_VDP_HOST_CTL_TIMEOUT_EN
  localparam int unsigned c_poll_w = $clog2(timeout_polls_p + 1);
  logic [c_poll_w-1:0] r_polls, w_polls_nxt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (timeout_polls_p == 0);
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_step  <= '0;
      r_gap   <= '0;
      r_err   <= 1'b0;
`ifdef BP_CACC_VDP_HOST_CTL_TIMEOUT_EN
      r_polls <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_gap   <= w_gap_nxt;
      r_err   <= w_err_nxt;
`ifdef BP_CACC_VDP_HOST_CTL_TIMEOUT_EN
      r_polls <= w_polls_nxt;
`endif
    end
  end

  // Descriptor is captured even for a bad length; it is simply never issued.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_a   <= '0;
      r_b   <= '0;
      r_len <= '0;
      r_res <= '0;
    end else if (w_job_fire) begin
      r_a   <= job_a_ptr_i;
      r_b   <= job_b_ptr_i;
      r_len <= job_len_i;
      r_res <= job_res_ptr_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_gap_nxt   = r_gap;
    w_err_nxt   = 1'b0;
`ifdef BP_CACC_VDP_HOST_CTL_TIMEOUT_EN
    w_polls_nxt = r_polls;
`endif
    case (r_state)
      S_IDLE: begin
        if (job_v_i) begin
          if (w_len_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
            w_step_nxt  = '0;
`ifdef BP_CACC_VDP_HOST_CTL_TIMEOUT_EN
            w_polls_nxt = '0;
`endif
          end
        end
      end
      S_ISSUE: begin
        if (io_cmd_ready_i) begin
          w_state_nxt = S_WAIT_RESP;
`ifdef BP_CACC_VDP_HOST_CTL_TIMEOUT_EN
          if (r_step == c_step_poll) w_polls_nxt = r_polls + c_poll_w'(1);
`endif
        end
      end
      S_WAIT_RESP: begin
        if (io_resp_v_i) begin
          if (r_step != c_step_poll) begin
            w_step_nxt  = r_step + 3'd1;
            w_state_nxt = S_ISSUE;
          end else if (io_resp_data_i == '0) begin
            w_state_nxt = S_DONE;
`ifdef BP_CACC_VDP_HOST_CTL_TIMEOUT_EN
          end else if (32'(r_polls) == timeout_polls_p) begin
            w_state_nxt = S_IDLE;
            w_err_nxt   = 1'b1;
`endif
          end else begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = '0;
          end
        end
      end
      S_GAP: begin
        // GAP always lasts at least one cycle, so poll_gap_p=0 still leaves it next cycle.
        if (32'(r_gap) + 32'd1 >= poll_gap_p) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_gap_nxt = r_gap + c_gap_w'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_off  = 9'h000;
    w_wr   = 1'b1;
    w_data = '0;
    case (r_step)
      3'd0: begin w_off = 9'h000; w_data = r_a;   end
      3'd1: begin w_off = 9'h040; w_data = r_b;   end
      3'd2: begin w_off = 9'h080; w_data = r_len; end
      3'd3: begin w_off = 9'h140; w_data = r_res; end
      3'd4: begin w_off = 9'h180; w_data = dword_width_p'(1); end
      3'd5: begin w_off = 9'h0c0; w_data = dword_width_p'(1); end
      default: begin w_off = 9'h0c0; w_wr = 1'b0; end
    endcase
  end

  assign io_cmd_v_o     = (r_state == S_ISSUE);
  assign io_cmd_wr_o    = io_cmd_v_o && w_wr;
  assign io_cmd_addr_o  = io_cmd_v_o ? (c_base + paddr_width_p'(w_off)) : '0;
  assign io_cmd_size_o  = io_cmd_v_o ? 3'd3 : 3'd0;
  assign io_cmd_data_o  = io_cmd_v_o ? w_data : '0;
  assign io_resp_yumi_o = (r_state == S_WAIT_RESP) && io_resp_v_i;
  assign job_ready_o    = (r_state == S_IDLE);
  assign busy_o         = (r_state != S_IDLE);
  assign done_v_o       = (r_state == S_DONE) || r_err;
  assign done_err_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bp_cacc_vdp_host_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bp_cacc_vdp_host_ctl                                       |
// | Brief    : Directed bench with a one-outstanding CSR responder model      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bp_cacc_vdp_host_ctl;

  localparam int unsigned c_paddr_w = 40;
  localparam int unsigned c_gap     = 2;
  localparam int unsigned c_tmo     = 3;

  logic                 clk_i, reset_n_i;
  logic                 job_v_i, job_ready_o;
  logic [63:0]          job_a_ptr_i, job_b_ptr_i, job_len_i, job_res_ptr_i;
  logic                 io_cmd_v_o, io_cmd_ready_i, io_cmd_wr_o;
  logic [c_paddr_w-1:0] io_cmd_addr_o;
  logic [2:0]           io_cmd_size_o;
  logic [63:0]          io_cmd_data_o;
  logic                 io_resp_v_i, io_resp_yumi_o;
  logic [63:0]          io_resp_data_i;
  logic                 busy_o, done_v_o, done_err_o;

  bp_cacc_vdp_host_ctl #(
    .paddr_width_p(c_paddr_w), .dword_width_p(64), .cacc_base_p(64'h0),
    .poll_gap_p(c_gap), .timeout_polls_p(c_tmo)
  ) u_dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .job_v_i(job_v_i), .job_ready_o(job_ready_o),
    .job_a_ptr_i(job_a_ptr_i), .job_b_ptr_i(job_b_ptr_i),
    .job_len_i(job_len_i), .job_res_ptr_i(job_res_ptr_i),
    .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_i(io_cmd_ready_i), .io_cmd_wr_o(io_cmd_wr_o),
    .io_cmd_addr_o(io_cmd_addr_o), .io_cmd_size_o(io_cmd_size_o), .io_cmd_data_o(io_cmd_data_o),
    .io_resp_v_i(io_resp_v_i), .io_resp_data_i(io_resp_data_i), .io_resp_yumi_o(io_resp_yumi_o),
    .busy_o(busy_o), .done_v_o(done_v_o), .done_err_o(done_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic                 wr;
    logic [c_paddr_w-1:0] addr;
    logic [63:0]          data;
    logic [2:0]           size;
    int                   cyc;
  } cmd_t;

  cmd_t        cmd_q[$];
  int          rd_resp_cyc[$];
  logic [63:0] poll_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hold_after = 32'h4000_0000;
  int          stall_cycles = 0;
  int          stall_cnt = 0;
  logic [63:0] stall_len_exp = '0;
  int          done_cnt = 0;
  logic        last_done_err = 1'b0;
  logic        pend = 1'b0, pend_wr = 1'b0, fire_cmd = 1'b0, fire_resp = 1'b0;
  logic [63:0] pend_data = '0;
  cmd_t        cap;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Accelerator model: one-cycle response latency, poll answers from poll_q (default 1).
  initial begin
    io_cmd_ready_i = 1'b0;
    io_resp_v_i    = 1'b0;
    io_resp_data_i = '0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!reset_n_i) begin
        pend = 1'b0; fire_cmd = 1'b0; fire_resp = 1'b0; io_cmd_ready_i = 1'b0;
      end else begin
        if (fire_resp) pend = 1'b0;
        if (fire_cmd) begin
          cmd_q.push_back(cap);
          pend    = 1'b1;
          pend_wr = cap.wr;
          pend_data = (!cap.wr && poll_q.size() > 0) ? poll_q.pop_front() : 64'd1;
        end
        if (stall_cnt > 0 && stall_cnt < stall_cycles) begin
          check("stall_v",    64'(io_cmd_v_o), 64'd1);
          check("stall_addr", 64'(io_cmd_addr_o), 64'h080);
          check("stall_data", io_cmd_data_o, stall_len_exp);
          stall_cnt++;
          io_cmd_ready_i = 1'b0;
        end else if (stall_cnt == 0 && stall_cycles > 0 && io_cmd_v_o &&
                     io_cmd_addr_o == 40'h080) begin
          check("stall_data0", io_cmd_data_o, stall_len_exp);
          stall_cnt = 1;
          io_cmd_ready_i = 1'b0;
        end else begin
          io_cmd_ready_i = 1'b1;
        end
        io_resp_v_i    = pend && (cmd_q.size() < hold_after);
        io_resp_data_i = pend_wr ? 64'hdead_beef : pend_data;
      end
      #1;
      fire_cmd  = reset_n_i && io_cmd_v_o && io_cmd_ready_i;
      fire_resp = reset_n_i && io_resp_v_i && io_resp_yumi_o;
      cap.wr = io_cmd_wr_o; cap.addr = io_cmd_addr_o; cap.data = io_cmd_data_o;
      cap.size = io_cmd_size_o; cap.cyc = cyc;
      if (fire_resp && !pend_wr) rd_resp_cyc.push_back(cyc);
      if (done_v_o) begin
        done_cnt++;
        last_done_err = done_err_o;
      end
    end
  end

  task automatic send_job(input logic [63:0] a, b, len, res);
    @(negedge clk_i);
    job_a_ptr_i = a; job_b_ptr_i = b; job_len_i = len; job_res_ptr_i = res;
    job_v_i = 1'b1;
    #2 check("job_ready", 64'(job_ready_o), 64'd1);
    @(negedge clk_i);
    job_v_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int prev = done_cnt;
    int n = 0;
    while (done_cnt == prev && n < budget) begin
      @(negedge clk_i);
      #2 n++;
    end
    check("done_seen", 64'(done_cnt != prev), 64'd1);
    @(negedge clk_i);
    #2 check("done_one_cycle", 64'(done_v_o), 64'd0);
    check("idle_after_done", 64'(job_ready_o), 64'd1);
  endtask

  task automatic check_seq(input int base, input logic [63:0] a, b, len, res, input int n_polls);
    logic [c_paddr_w-1:0] exp_addr[6];
    logic [63:0]          exp_data[6];
    exp_addr = '{40'h000, 40'h040, 40'h080, 40'h140, 40'h180, 40'h0c0};
    exp_data = '{a, b, len, res, 64'd1, 64'd1};
    check("cmd_count", 64'(cmd_q.size() - base), 64'(6 + n_polls));
    for (int i = 0; i < 6 + n_polls && base + i < cmd_q.size(); i++) begin
      check("cmd_size", 64'(cmd_q[base+i].size), 64'd3);
      if (i < 6) begin
        check("wr_flag", 64'(cmd_q[base+i].wr), 64'd1);
        check("wr_addr", 64'(cmd_q[base+i].addr), 64'(exp_addr[i]));
        check("wr_data", cmd_q[base+i].data, exp_data[i]);
      end else begin
        check("poll_flag", 64'(cmd_q[base+i].wr), 64'd0);
        check("poll_addr", 64'(cmd_q[base+i].addr), 64'h0c0);
        check("poll_data", cmd_q[base+i].data, 64'd0);
      end
    end
  endtask

  initial begin
    int base, n, idle, lens_seen;
    reset_n_i = 1'b0; job_v_i = 1'b0;
    job_a_ptr_i = '0; job_b_ptr_i = '0; job_len_i = '0; job_res_ptr_i = '0;
    repeat (2) @(negedge clk_i);
    #2;
    check("rst_ready", 64'(job_ready_o), 64'd1);
    check("rst_busy",  64'(busy_o), 64'd0);
    check("rst_cmd_v", 64'(io_cmd_v_o), 64'd0);
    check("rst_done",  64'(done_v_o), 64'd0);
    check("rst_yumi",  64'(io_resp_yumi_o), 64'd0);
    reset_n_i = 1'b1;

    // Nominal job: two busy polls then idle.
    poll_q = '{64'd1, 64'd1, 64'd0};
    rd_resp_cyc.delete();
    base = cmd_q.size();
    send_job(64'h8000_0000, 64'h8000_0100, 64'd4, 64'h8000_0200);
    wait_done(400);
    check("job1_err", 64'(last_done_err), 64'd0);
    check_seq(base, 64'h8000_0000, 64'h8000_0100, 64'd4, 64'h8000_0200, 3);
    for (int i = 0; i < 2; i++) begin
      if (base + 7 + i < cmd_q.size() && i < rd_resp_cyc.size()) begin
        idle = cmd_q[base+7+i].cyc - rd_resp_cyc[i] - 1;
        check("poll_gap_ok", 64'(idle >= int'(c_gap)), 64'd1);
      end
    end

    // Bad lengths: no bus traffic, error pulse the cycle after acceptance.
    foreach (poll_q[i]) poll_q.delete(i);
    for (int k = 0; k < 2; k++) begin
      base = cmd_q.size();
      @(negedge clk_i);
      job_len_i = (k == 0) ? 64'd0 : 64'd9;
      job_v_i = 1'b1;
      #2 check("bad_ready", 64'(job_ready_o), 64'd1);
      @(negedge clk_i);
      job_v_i = 1'b0;
      #2;
      check("bad_done_v",   64'(done_v_o), 64'd1);
      check("bad_done_err", 64'(done_err_o), 64'd1);
      check("bad_no_cmd",   64'(io_cmd_v_o), 64'd0);
      @(negedge clk_i);
      #2 check("bad_pulse_end", 64'(done_v_o), 64'd0);
      check("bad_no_traffic", 64'(cmd_q.size() - base), 64'd0);
    end

    // Stalled LEN write plus a second job offered while busy.
    poll_q = '{64'd0};
    stall_cycles = 5; stall_cnt = 0; stall_len_exp = 64'd3;
    base = cmd_q.size();
    send_job(64'h1111_0000, 64'h2222_0000, 64'd3, 64'h3333_0000);
    job_a_ptr_i = 64'hbad0; job_b_ptr_i = 64'hbad1; job_len_i = 64'd5; job_res_ptr_i = 64'hbad2;
    job_v_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      #2;
      check("busy_not_ready", 64'(job_ready_o), 64'd0);
      check("busy_flag", 64'(busy_o), 64'd1);
    end
    job_v_i = 1'b0;
    wait_done(400);
    check("job2_err", 64'(last_done_err), 64'd0);
    check_seq(base, 64'h1111_0000, 64'h2222_0000, 64'd3, 64'h3333_0000, 1);
    check("stall_cycles", 64'(stall_cnt), 64'd5);
    lens_seen = 0;
    for (int i = base; i < cmd_q.size(); i++)
      if (cmd_q[i].addr == 40'h080) lens_seen++;
    check("len_handshakes", 64'(lens_seen), 64'd1);
    stall_cycles = 0; stall_cnt = 0;

    // Reset while waiting on the RES_PTR write response.
    poll_q = '{64'd0};
    base = cmd_q.size();
    hold_after = base + 4;
    send_job(64'h8000_0000, 64'h8000_0100, 64'd4, 64'h8000_0200);
    n = 0;
    while (cmd_q.size() < base + 4 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("reached_step3", 64'(cmd_q.size() - base), 64'd4);
    @(negedge clk_i);
    #2;
    check("mid_busy", 64'(busy_o), 64'd1);
    reset_n_i = 1'b0;
    #1;
    check("arst_busy",  64'(busy_o), 64'd0);
    check("arst_ready", 64'(job_ready_o), 64'd1);
    check("arst_cmd_v", 64'(io_cmd_v_o), 64'd0);
    check("arst_yumi",  64'(io_resp_yumi_o), 64'd0);
    check("arst_done",  64'(done_v_o), 64'd0);
    @(negedge clk_i);
    #2 reset_n_i = 1'b1;
    hold_after = 32'h4000_0000;
    check("arst_no_done", 64'(done_v_o), 64'd0);
    poll_q = '{64'd0};
    base = cmd_q.size();
    send_job(64'h0abc_0000, 64'h0abc_0100, 64'd8, 64'h0abc_0200);
    wait_done(400);
    check_seq(base, 64'h0abc_0000, 64'h0abc_0100, 64'd8, 64'h0abc_0200, 1);

    // START never clears.
    foreach (poll_q[i]) poll_q.delete(i);
    base = cmd_q.size();
    send_job(64'h8000_0000, 64'h8000_0100, 64'd4, 64'h8000_0200);
`ifdef BP_CACC_VDP_HOST_CTL_TIMEOUT_EN
    wait_done(600);
    check("tmo_err", 64'(last_done_err), 64'd1);
    check_seq(base, 64'h8000_0000, 64'h8000_0100, 64'd4, 64'h8000_0200, int'(c_tmo));
`else
    n = done_cnt;
    repeat (150) @(negedge clk_i);
    #2;
    check("poll_forever_no_done", 64'(done_cnt - n), 64'd0);
    check("poll_forever_busy", 64'(busy_o), 64'd1);
    check("poll_forever_many", 64'((cmd_q.size() - base) > 6 + int'(c_tmo)), 64'd1);
    reset_n_i = 1'b0;
    @(negedge clk_i);
    #2 reset_n_i = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
